// File: rtl/proj_pkg.sv
// Shared FSM encoding and default sizing for the program loader.
// Pure declarations: no latency or backpressure of its own.
package proj_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WIPE,
    ST_LOAD,
    ST_CORE_RST,
    ST_RUN,
    ST_HALTED
  } state_t;

  // A new session may only be launched from a quiescent state.
  function automatic logic can_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/clr_hold_cnt.sv
// Down-counter that times the core reset window; loaded with CYCLES-1.
// last is combinational from the count; no backpressure.
module clr_hold_cnt #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] INIT = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= INIT;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/prog_load_ctrl.sv
// Session controller: wipe program memory, stream len words in, pulse core reset, run until halt.
// Writes appear one cycle after acceptance; in_ready throttles the loader, in_valid gaps stall it.
module prog_load_ctrl
  import proj_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              halt_req,
  output logic              prog_w,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              core_clr,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LAST_ADDR = DEPTH - ONE;

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len_q;

  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic accept;
  logic last_accept;
  logic hold_last;

  assign len_ok      = (len != '0) && (len <= DEPTH);
  assign start_ok    = start && can_start(state) && len_ok;
  assign start_bad   = start && can_start(state) && !len_ok;
  assign in_ready    = (state == ST_LOAD) && (cnt < len_q);
  assign accept      = in_ready && in_valid;
  assign last_accept = accept && (cnt == (len_q - ONE));

  clr_hold_cnt #(
    .CYCLES (CLR_CYCLES)
  ) u_clr_hold (
    .clk  (clk),
    .clr  (clr),
    .load (last_accept),
    .dec  (state == ST_CORE_RST),
    .last (hold_last)
  );

  // Outputs are assigned alongside the state transition so they line up with the state they describe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      prog_w    <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      core_clr  <= 1'b1;
      core_run  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_w <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start_ok) begin
            len_q    <= len;
            cnt      <= '0;
            state    <= ST_WIPE;
            busy     <= 1'b1;
            done     <= 1'b0;
            core_clr <= 1'b0;
          end else if (start_bad) begin
            err <= 1'b1;
          end
        end

        ST_WIPE: begin
          prog_w    <= 1'b1;
          prog_addr <= cnt[ADDR_W-1:0];
          prog_data <= '0;
          if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            prog_w    <= 1'b1;
            prog_addr <= cnt[ADDR_W-1:0];
            prog_data <= in_data;
            cnt       <= cnt + ONE;
            if (last_accept) begin
              state    <= ST_CORE_RST;
              core_clr <= 1'b1;
            end
          end
        end

        ST_CORE_RST: begin
          if (hold_last) begin
            state    <= ST_RUN;
            core_clr <= 1'b0;
            core_run <= 1'b1;
          end
        end

        ST_RUN: begin
          if (halt_req) begin
            state    <= ST_HALTED;
            core_run <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          core_clr <= 1'b1;
          core_run <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
